// File: rtl/psram_pkg.sv
// Shared command codes, FSM state encoding and command decoder for the QSPI PSRAM target.
// When QSPI_PSRAM_QPI_EN is defined, 0x35/0xF5 decode as mode commands instead of unsupported ones.
package psram_pkg;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

  typedef enum logic [1:0] {
    CMD_KIND_READ,
    CMD_KIND_WRITE,
    CMD_KIND_MODE,
    CMD_KIND_BAD
  } cmd_kind_t;

  function automatic cmd_kind_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_QREAD:              return CMD_KIND_READ;
      CMD_QWRITE:             return CMD_KIND_WRITE;
`ifdef QSPI_PSRAM_QPI_EN
      CMD_QPI_EN, CMD_QPI_EX: return CMD_KIND_MODE;
`else
      CMD_QPI_EN, CMD_QPI_EX: return CMD_KIND_BAD;
`endif
      default:                return CMD_KIND_BAD;
    endcase
  endfunction

endpackage

// File: rtl/qspi_psram_target_if.sv
// QSPI link between a PSRAM controller (master) and the PSRAM target (slave).
interface qspi_psram_target_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;
  logic       cmd_err;

  modport master (output sck, ce_n, din, input dout, douten, cmd_err);
  modport slave  (input sck, ce_n, din, output dout, douten, cmd_err);
endinterface

// File: rtl/psram_byte_mem.sv
// Single-port byte array: byte write and registered (1-cycle) read on the same address.
module psram_byte_mem #(
  parameter int MEM_AW = 12
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<MEM_AW)-1];

  // NOTE: the array and read register carry no reset: contents must survive rst_i,
  // and a reset would prevent mapping onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/qspi_psram_target.sv
// QSPI PSRAM target: oversamples sck on clk_i, decodes 0xEB/0x38, serves an internal byte array.
// Optional QPI command mode (0x35 enter / 0xF5 exit) is built when QSPI_PSRAM_QPI_EN is defined.
module qspi_psram_target
  import psram_pkg::*;
#(
  parameter int MEM_AW       = 12,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  qspi_psram_target_if.slave  bus
);

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t            state_q, state_n;
  logic              sck_d;
  logic              rise, fall;
  logic [7:0]        cnt_q;
  logic [6:0]        cmd_q;
  logic [MEM_AW-1:0] addr_q;
  logic              is_wr_q;
  logic              nib_lo_q;
  logic [3:0]        wr_hi_q;
  logic [3:0]        dout_q, douten_q;
  logic              cmd_err_q;

  logic [7:0]        cmd_shift;
  logic              cmd_last;
  cmd_kind_t         cmd_kind;
  logic              mem_we;
  logic [7:0]        mem_rdata;

`ifdef QSPI_PSRAM_QPI_EN
  logic qpi_q, mode_pend_q, mode_val_q;
`endif

  assign rise = bus.sck & ~sck_d & ~bus.ce_n;
  assign fall = ~bus.sck & sck_d & ~bus.ce_n;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    cmd_shift = {cmd_q, bus.din[0]};
    cmd_last  = (cnt_q == 8'd7);
`ifdef QSPI_PSRAM_QPI_EN
    if (qpi_q) begin
      cmd_shift = {cmd_q[3:0], bus.din};
      cmd_last  = (cnt_q == 8'd1);
    end
`endif
    cmd_kind = decode_cmd(cmd_shift);

    state_n = state_q;
    if (bus.ce_n) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_n = CMD;
        CMD:   if (rise && cmd_last)
                 state_n = (cmd_kind == CMD_KIND_READ || cmd_kind == CMD_KIND_WRITE) ? ADDR : IGNORE;
        ADDR:  if (rise && cnt_q == ADDR_LAST) state_n = is_wr_q ? WDATA : DUMMY;
        DUMMY: if (rise && cnt_q == DUMMY_LAST) state_n = RDATA;
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Byte commits on the second data rise; a lone high nibble is dropped at ce_n rise.
  assign mem_we = (state_q == WDATA) && rise && nib_lo_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_d     <= 1'b0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      nib_lo_q  <= 1'b0;
      wr_hi_q   <= '0;
      dout_q    <= '0;
      douten_q  <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      sck_d     <= bus.sck;
      cmd_err_q <= 1'b0;
      if (bus.ce_n) begin
        cnt_q    <= '0;
        nib_lo_q <= 1'b0;
        dout_q   <= '0;
        douten_q <= '0;
      end else begin
        case (state_q)
          CMD: if (rise) begin
            cmd_q <= cmd_shift[6:0];
            cnt_q <= cmd_last ? 8'd0 : cnt_q + 8'd1;
            if (cmd_last) begin
              is_wr_q   <= (cmd_kind == CMD_KIND_WRITE);
              cmd_err_q <= (cmd_kind == CMD_KIND_BAD);
            end
          end
          ADDR: if (rise) begin
            // Only the low MEM_AW address bits are kept; upper bits shift out.
            addr_q <= MEM_AW'({addr_q, bus.din});
            cnt_q  <= (cnt_q == ADDR_LAST) ? 8'd0 : cnt_q + 8'd1;
          end
          DUMMY: if (rise) cnt_q <= (cnt_q == DUMMY_LAST) ? 8'd0 : cnt_q + 8'd1;
          RDATA: if (fall) begin
            douten_q <= 4'hF;
            nib_lo_q <= ~nib_lo_q;
            if (!nib_lo_q) begin
              dout_q <= mem_rdata[7:4];
            end else begin
              dout_q <= mem_rdata[3:0];
              addr_q <= addr_q + 1'b1;
            end
          end
          WDATA: if (rise) begin
            nib_lo_q <= ~nib_lo_q;
            if (!nib_lo_q) wr_hi_q <= bus.din;
            else           addr_q  <= addr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef QSPI_PSRAM_QPI_EN
  // Mode commands are only armed here; the switch happens once ce_n goes high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qpi_q       <= 1'b0;
      mode_pend_q <= 1'b0;
      mode_val_q  <= 1'b0;
    end else if (bus.ce_n) begin
      if (mode_pend_q) qpi_q <= mode_val_q;
      mode_pend_q <= 1'b0;
    end else if (state_q == CMD && rise && cmd_last && cmd_kind == CMD_KIND_MODE) begin
      mode_pend_q <= 1'b1;
      mode_val_q  <= (cmd_shift == CMD_QPI_EN);
    end
  end
`endif

  psram_byte_mem #(.MEM_AW(MEM_AW)) u_mem (
    .clk_i (clk_i),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata ({wr_hi_q, bus.din}),
    .rdata (mem_rdata)
  );

  assign bus.dout    = dout_q;
  assign bus.douten  = douten_q;
  assign bus.cmd_err = cmd_err_q;

endmodule
